// File: rtl/tribus_arbiter_pkg.sv
// Shared encodings and defaults for the tri-state bus arbiter.
// No logic here; types and constants only.
// Imported by the picker, interface users and the arbiter top.
package arb_pkg;

    // Arbiter FSM encodings
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } arb_state_t;

    // Default burst cap while other requesters are waiting
    localparam int MAX_HOLD_DEFAULT = 8;

    // Width of an encoded requester index (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tribus_arbiter_if.sv
// Request/grant bundle between requesters and the tri-state bus arbiter.
// Grant side outputs are registered inside the arbiter; no combinational return path.
// No backpressure: req is a level held while the bus is wanted.
interface tribus_arbiter_if #(
    parameter int N = 4
);
    import arb_pkg::*;

    localparam int W = idx_width(N);

    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] oe_n;
    logic [W-1:0] owner;
    logic         busy;

    // Arbiter side
    modport master (
        input  req,
        output gnt,
        output oe_n,
        output owner,
        output busy
    );

    // Requester side
    modport slave (
        output req,
        input  gnt,
        input  oe_n,
        input  owner,
        input  busy
    );

endinterface

// File: rtl/tribus_arbiter_rr_pick.sv
// Round-robin picker: first set req bit searching from (last+1) mod N upwards.
// Purely combinational, zero latency.
// No backpressure; any=0 when no request is set.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] win,
    output logic [W-1:0] idx,
    output logic         any
);

    // Walk the rotated order once and keep the first hit
    always_comb begin
        int cand;
        win  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                win[cand] = 1'b1;
                idx       = W'(cand);
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus, one all-off turnaround between owners.
// Grant one cycle after req is sampled; release takes one TURN cycle before the next grant.
// Owner holds while req stays high; capped at MAX_HOLD cycles only when others are waiting.
module tribus_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    tribus_arbiter_if.master bus
);

    localparam int         W        = idx_width(N);
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [W-1:0] LAST_RST = W'(N - 1);

    arb_state_t   state;
    logic [7:0]   hold_cnt;
    logic [W-1:0] last;
    logic [N-1:0] gnt_q;
    logic [N-1:0] oe_n_q;
    logic [W-1:0] owner_q;
    logic         busy_q;

    logic [N-1:0] pick_win;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         own_req;
    logic         others_req;
    logic         cap_hit;

    rr_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req  (bus.req),
        .last (last),
        .win  (pick_win),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Release conditions seen by the current owner
    always_comb begin
        own_req    = bus.req[owner_q];
        others_req = |(bus.req & ~gnt_q);
        cap_hit    = (hold_cnt == HOLD_MAX);
    end

    // Arbiter FSM with hold counter and registered bus controls
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= LAST_RST;
            gnt_q    <= '0;
            oe_n_q   <= '1;
            owner_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    // TURN arbitrates exactly like IDLE; it only guarantees the dead cycle
                    if (pick_any) begin
                        state    <= GRANT;
                        hold_cnt <= 8'd1;
                        last     <= pick_idx;
                        gnt_q    <= pick_win;
                        oe_n_q   <= ~pick_win;
                        owner_q  <= pick_idx;
                        busy_q   <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        gnt_q    <= '0;
                        oe_n_q   <= '1;
                        owner_q  <= '0;
                        busy_q   <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!own_req || (cap_hit && others_req)) begin
                        // Drop all enables for one cycle before anyone else drives
                        state   <= TURN;
                        gnt_q   <= '0;
                        oe_n_q  <= '1;
                        owner_q <= '0;
                        busy_q  <= 1'b1;
                    end else if (!cap_hit) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_q   <= '0;
                    oe_n_q  <= '1;
                    owner_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.oe_n  = oe_n_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
module tb_tribus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    tribus_arbiter_if #(.N(N)) bus ();

    tribus_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    // Reference model: who owns the bus, whether we are in the dead cycle, tenure length
    int m_owner  = -1;
    bit m_gap    = 1'b0;
    int m_tenure = 0;
    int m_last   = N - 1;

    function automatic exp_t model_step(input bit rst, input logic [3:0] r);
        exp_t e;
        bit others;
        if (rst) begin
            m_owner  = -1;
            m_gap    = 1'b0;
            m_tenure = 0;
            m_last   = N - 1;
        end else if (m_owner >= 0) begin
            others = 1'b0;
            for (int j = 0; j < N; j++)
                if (j != m_owner && r[j]) others = 1'b1;
            if (r[m_owner] && !(m_tenure >= MAX_HOLD && others)) begin
                m_tenure = (m_tenure + 1 > MAX_HOLD) ? MAX_HOLD : m_tenure + 1;
            end else begin
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else begin
            m_gap = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && r[c]) begin
                    m_owner  = c;
                    m_last   = c;
                    m_tenure = 1;
                end
            end
        end
        e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.owner = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.busy  = (m_owner >= 0) || m_gap;
        return e;
    endfunction

    // Apply inputs for one cycle; the model predicts what the DUT shows after the edge
    task automatic cycle(input bit rst, input logic [3:0] r);
        reset   = rst;
        bus.req = r;
        @(posedge clk);
        #1;
        exp_q.push_back(model_step(rst, r));
    endtask

    task automatic run(input bit rst, input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) cycle(rst, r);
    endtask

    // Monitor: pop one expectation per presented cycle and check bus invariants
    initial begin : monitor
        exp_t       e;
        logic [3:0] prev_gnt;
        int         zeros;
        prev_gnt = 4'b0000;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.gnt !== e.gnt || bus.owner !== e.owner || bus.busy !== e.busy) begin
                    bad++;
                    $display("FAIL outputs t=%0t gnt=%b owner=%0d busy=%b expected gnt=%b owner=%0d busy=%b",
                             $time, bus.gnt, bus.owner, bus.busy, e.gnt, e.owner, e.busy);
                end
                total++;
                if (bus.oe_n !== ~e.gnt) begin
                    bad++;
                    $display("FAIL oe_n t=%0t oe_n=%b expected %b", $time, bus.oe_n, ~e.gnt);
                end
                zeros = 0;
                for (int j = 0; j < N; j++) if (bus.oe_n[j] === 1'b0) zeros++;
                total++;
                if (zeros > 1 || bus.oe_n !== ~bus.gnt) begin
                    bad++;
                    $display("FAIL enable_invariant t=%0t oe_n=%b gnt=%b", $time, bus.oe_n, bus.gnt);
                end
                total++;
                if (prev_gnt != 4'b0000 && bus.gnt != 4'b0000 && prev_gnt !== bus.gnt) begin
                    bad++;
                    $display("FAIL turnaround t=%0t prev_gnt=%b gnt=%b expected a zero cycle between",
                             $time, prev_gnt, bus.gnt);
                end
                prev_gnt = bus.gnt;
            end
        end
    end

    // Stimulus: directed scenarios then randomized traffic
    initial begin : stimulus
        logic [3:0] r;
        reset   = 1'b1;
        bus.req = 4'b0000;

        // Reset held with everyone requesting, then first grant goes to 0
        run(1'b1, 4'b1111, 2);
        run(1'b0, 4'b1111, 3);
        run(1'b0, 4'b0000, 12);

        // Single requester: three cycles of req then release
        run(1'b1, 4'b0000, 1);
        run(1'b0, 4'b0001, 3);
        run(1'b0, 4'b0000, 3);

        // Saturation: rotation 0,1,2,3,0 with period MAX_HOLD+1
        run(1'b0, 4'b1111, 5 * (MAX_HOLD + 1) + 2);
        run(1'b0, 4'b0000, 3);

        // Lone requester is never capped
        run(1'b0, 4'b0100, 20);
        run(1'b0, 4'b0000, 3);

        // Handover race: owner 1 drops on the edge requester 3 raises
        run(1'b1, 4'b0000, 1);
        run(1'b0, 4'b0010, 3);
        run(1'b0, 4'b1000, 4);
        run(1'b0, 4'b0000, 3);

        // Reset in the 4th cycle of a grant to requester 2
        run(1'b0, 4'b0100, 4);
        run(1'b1, 4'b0100, 1);
        run(1'b0, 4'b0100, 3);
        run(1'b0, 4'b0000, 3);

        // Forced release while the old owner keeps requesting alongside one other
        run(1'b0, 4'b0001, 2);
        run(1'b0, 4'b0011, 22);
        run(1'b0, 4'b0000, 3);

        // Randomized traffic with sticky request levels and rare resets
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < N; j++)
                if ($urandom_range(0, 3) == 0) r[j] = ~r[j];
            cycle($urandom_range(0, 99) == 0, r);
        end
        run(1'b0, 4'b0000, 4);

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tribus_arbiter.md
# tribus_arbiter

Round-robin arbiter for a shared 32-bit tri-state bus. Each requester drives the bus through its own 32-bit buffer with an active-low enable. This block produces those active-low enables, so at most one driver is ever enabled. It inserts one all-off turnaround cycle between owners to prevent bus contention, and caps each ownership at a fixed burst length when other requesters are waiting.

## Interface
Parameters:
- N, 4: number of requesters (2..8).
- MAX_HOLD, 8: cycles an owner may keep the bus while another requester is pending (1..255).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  per-requester bus request; level, held while the bus is wanted.
- gnt  output  N  one-hot grant, registered; all zeros when nobody owns the bus.
- oe_n  output  N  active-low driver enables, wired to the tri-state buffer controls; always equal to ~gnt.
- owner  output  clog2(N)  encoded index of current owner; 0 when gnt is zero.
- busy  output  1  high when any grant is active or a turnaround is in progress.

## Operation
- States:
  - IDLE: no owner, waiting for requests.
  - GRANT: one owner drives the bus.
  - TURN: exactly one cycle, all enables off.
- IDLE: if any req bit is sampled high, go to GRANT with the round-robin winner. Otherwise stay in IDLE.
- Round-robin rule: the search starts at index (last+1) mod N and picks the first set req bit. last is the most recent owner; reset value of last is N-1, so index 0 wins first.
- Entering GRANT sets hold_cnt = 1 and last = winner.
- GRANT, owner's req sampled low: go to TURN.
- GRANT, owner's req sampled high, hold_cnt == MAX_HOLD, and another req bit is high: forced release, go to TURN.
- GRANT, owner's req sampled high, otherwise: stay in GRANT. hold_cnt increments, saturating at MAX_HOLD.
- TURN: gnt = 0 and oe_n = all ones. On the next edge, arbitrate exactly as IDLE does:
  - any req set: GRANT to the new winner;
  - no req set: IDLE.
- Forced release: the released owner rejoins arbitration behind the others because of the rotated pointer. It can win again only if no other req is set.
- Invariants, checked every cycle:
  - oe_n has at most one zero bit;
  - oe_n == ~gnt;
  - gnt is never nonzero in consecutive cycles with different owners (a TURN cycle always separates them).
- Requests from one requester that arrive while another owns the bus are not lost; they remain pending as long as req stays high. No request latching: a req pulse dropped before arbitration is ignored.

## Timing
- All outputs are registered; there is no combinational path from req to gnt, oe_n, owner or busy.
- Grant latency: req high in cycle c from IDLE gives gnt/oe_n active in cycle c+1.
- Release latency: owner req low in cycle c gives TURN in cycle c+1. The earliest next grant is cycle c+2.
- Back-to-back saturated traffic: each owner holds for MAX_HOLD cycles, then one TURN cycle, giving a period of MAX_HOLD+1.
- Reset values: gnt = 0, oe_n = all ones, owner = 0, busy = 0, state = IDLE, hold_cnt = 0, last = N-1.
- Reset asserted mid-GRANT or mid-TURN: all enables are off in the cycle after the reset edge. Reset has priority over every other event.
- Owner drops req on the same edge another requester raises req: TURN first, then grant. The bus is never handed over without a turnaround.

## Structure
- Shared package arb_pkg holds:
  - the state encodings: IDLE = 2'b00, GRANT = 2'b01, TURN = 2'b10;
  - the default MAX_HOLD constant.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N-1:0], last index.
  - Outputs: one-hot winner, encoded index, any.
- The arbiter top contains the FSM, the hold counter and the output registers.

## Test plan
All scenarios use N = 4, MAX_HOLD = 8.
- Reset: hold reset for 2 cycles with req = 4'b1111 -> gnt = 0, oe_n = 4'b1111, busy = 0 throughout; first grant after release is gnt = 4'b0001.
- Single requester: req = 4'b0001 high in cycles 0-2, low from cycle 3 -> gnt = 4'b0001 and oe_n = 4'b1110 in cycles 1-3; TURN in cycle 4; IDLE with busy = 0 in cycle 5.
- Saturation: req = 4'b1111 held continuously -> owners 0, 1, 2, 3, 0 in order; each holds for 8 cycles, separated by one all-ones oe_n cycle; period 9.
- No competitor: req = 4'b0100 for 20 cycles -> gnt = 4'b0100 for 20 consecutive cycles, no forced release, hold_cnt saturates at 8.
- Handover race: owner 1 drops req on the same edge requester 3 raises req -> one TURN cycle with oe_n = 4'b1111, then gnt = 4'b1000.
- Reset mid-burst: assert reset in the 4th cycle of a grant to requester 2 -> oe_n = 4'b1111 on the next cycle; after reset release with req = 4'b0100, requester 2 is granted one cycle later.
